// File: rtl/sad_min_select_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sad_min_select_if : SAD write snoop port and result handshake       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface sad_min_select_if #(
  parameter int S_WIDTH = 32,
  parameter int C_WIDTH = 7
);
  logic               Start;
  logic               O_En;
  logic               O_RW;
  logic [C_WIDTH-1:0] C_Addr;
  logic [S_WIDTH-1:0] SAD_In;
  logic               SAD_Done;
  logic [S_WIDTH-1:0] Thresh;
  logic               Ack;
  logic [S_WIDTH-1:0] Best_SAD;
  logic [C_WIDTH-1:0] Best_Idx;
  logic [C_WIDTH:0]   Count;
  logic [C_WIDTH:0]   Hit_Cnt;
  logic               Valid;
  logic               Busy;

  modport master (
    output Start, O_En, O_RW, C_Addr, SAD_In, SAD_Done, Thresh, Ack,
    input  Best_SAD, Best_Idx, Count, Hit_Cnt, Valid, Busy
  );

  modport slave (
    input  Start, O_En, O_RW, C_Addr, SAD_In, SAD_Done, Thresh, Ack,
    output Best_SAD, Best_Idx, Count, Hit_Cnt, Valid, Busy
  );
endinterface
`default_nettype wire

// File: rtl/sad_min_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sad_min_select : per-pass minimum SAD / threshold hit tracker       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sad_min_select #(
  parameter int S_WIDTH = 32,
  parameter int C_WIDTH = 7
) (
  input  logic               Clk,
  input  logic               Rst,
  sad_min_select_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [S_WIDTH-1:0] c_sad_max = '1;
  localparam logic [C_WIDTH:0]   c_cnt_max = '1;
  localparam logic [C_WIDTH:0]   c_cnt_one = {{C_WIDTH{1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next;
  logic [S_WIDTH-1:0] r_best_sad;
  logic [C_WIDTH-1:0] r_best_idx;
  logic [C_WIDTH:0]   r_count;
  logic [C_WIDTH:0]   r_hit_cnt;
  logic               w_strobe;
  logic               w_clear;
  logic               w_sample;

  assign w_strobe = bus.O_En & bus.O_RW;
  // Start outranks a same-cycle strobe, so a restart never keeps stale samples.
  assign w_clear  = bus.Start & ((r_state == ST_IDLE) | (r_state == ST_TRACK));
  assign w_sample = (r_state == ST_TRACK) & ~bus.Start & w_strobe;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.Start) w_next = ST_TRACK;
      ST_TRACK:  if (!bus.Start && bus.SAD_Done) w_next = ST_REPORT;
      ST_REPORT: if (bus.Ack) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_best_sad <= '0;
      r_best_idx <= '0;
      r_count    <= '0;
      r_hit_cnt  <= '0;
    end else if (w_clear) begin
      r_best_sad <= c_sad_max;
      r_best_idx <= '0;
      r_count    <= '0;
      r_hit_cnt  <= '0;
    end else if (w_sample) begin
      // Strict compare: ties keep the earliest candidate.
      if (bus.SAD_In < r_best_sad) begin
        r_best_sad <= bus.SAD_In;
        r_best_idx <= bus.C_Addr;
      end
      if (r_count != c_cnt_max) r_count <= r_count + c_cnt_one;
      if ((bus.SAD_In < bus.Thresh) && (r_hit_cnt != c_cnt_max))
        r_hit_cnt <= r_hit_cnt + c_cnt_one;
    end
  end

  assign bus.Best_SAD = r_best_sad;
  assign bus.Best_Idx = r_best_idx;
  assign bus.Count    = r_count;
  assign bus.Hit_Cnt  = r_hit_cnt;
  assign bus.Valid    = (r_state == ST_REPORT);
  assign bus.Busy     = (r_state == ST_TRACK);

endmodule
`default_nettype wire
